// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: machine word and fetch-stage states
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DROP,
      HALTED
   } fetch_state_t;

   localparam word_t WORD_STEP = 32'd4;

   // Targets arrive from the ALU; the low two bits are never meaningful for a word fetch.
   function automatic word_t align_word(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response handshake
interface fetch_stage_if;
   import cpu_types_pkg::*;

   logic  iREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;

   modport master (output iREN, imemaddr, input ihit, imemload);
   modport slave  (input iREN, imemaddr, output ihit, imemload);
endinterface

// File: rtl/fetch_stage_buffer.sv
// rtl/fetch_stage_buffer.sv - single-entry holding register for a stalled fetch
module fetch_buffer
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  load,
   input  logic  clear,
   input  word_t instr_d,
   input  word_t pc_d,
   output logic  valid,
   output word_t instr_q,
   output word_t pc_q
);
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid   <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid   <= 1'b1;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage feeding the IF/ID pipeline register
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          stall,
   input  logic          redirect,
   input  word_t         redirect_pc,
   input  logic          halt_req,
   fetch_stage_if.master imem,
   output word_t         ifid_instruction,
   output word_t         ifid_pcn,
   output word_t         ifid_next_address,
   output logic          ifid_flushed,
   output logic          ifid_wen,
   output logic          ifid_flush,
   output word_t         fetch_count
);
   fetch_state_t state, state_n;
   word_t        pc, pc_n;
   word_t        target_q, target_n;
   logic         halt_pend, halt_pend_n;
   logic         buf_load, buf_clear, buf_valid;
   word_t        buf_instr, buf_pc;
   word_t        rpc;

   logic  iren;
   word_t instr, pcn, next_addr;
   logic  flushed, wen, flush;

   assign rpc = align_word(redirect_pc);

   fetch_buffer u_buffer (
      .CLK     (CLK),
      .nRST    (nRST),
      .load    (buf_load),
      .clear   (buf_clear),
      .instr_d (imem.imemload),
      .pc_d    (pc),
      .valid   (buf_valid),
      .instr_q (buf_instr),
      .pc_q    (buf_pc)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= FETCH;
         pc          <= PC_INIT;
         target_q    <= '0;
         halt_pend   <= 1'b0;
         fetch_count <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         target_q  <= target_n;
         halt_pend <= halt_pend_n;
         if (wen && !flushed)
            fetch_count <= fetch_count + 32'd1;
      end
   end

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      target_n    = target_q;
      halt_pend_n = halt_pend;
      buf_load    = 1'b0;
      buf_clear   = 1'b0;
      iren        = 1'b0;
      instr       = '0;
      pcn         = '0;
      next_addr   = '0;
      flushed     = 1'b0;
      wen         = 1'b0;
      flush       = 1'b0;

      // A redirect always squashes IF/ID and, unless stalled, writes a bubble.
      if (redirect) begin
         flush       = 1'b1;
         halt_pend_n = 1'b0;
         if (!stall) begin
            wen     = 1'b1;
            flushed = 1'b1;
         end
      end

      case (state)
         FETCH: begin
            iren = 1'b1;
            if (redirect) begin
               if (imem.ihit) begin
                  pc_n = rpc;
               end else begin
                  target_n = rpc;
                  state_n  = DROP;
               end
            end else if (imem.ihit) begin
               if (halt_pend) begin
                  halt_pend_n = 1'b0;
                  state_n     = HALTED;
               end else if (!stall) begin
                  instr     = imem.imemload;
                  pcn       = pc;
                  next_addr = pc + WORD_STEP;
                  wen       = 1'b1;
                  pc_n      = pc + WORD_STEP;
                  if (halt_req)
                     state_n = HALTED;
               end else if (halt_req) begin
                  state_n = HALTED;
               end else begin
                  buf_load = 1'b1;
                  state_n  = HOLD;
               end
            end else if (halt_req) begin
               halt_pend_n = 1'b1;
            end
         end

         HOLD: begin
            if (redirect) begin
               buf_clear = 1'b1;
               pc_n      = rpc;
               state_n   = FETCH;
            end else begin
               instr     = buf_instr;
               pcn       = buf_pc;
               next_addr = buf_pc + WORD_STEP;
               if (!stall && buf_valid) begin
                  wen       = 1'b1;
                  pc_n      = buf_pc + WORD_STEP;
                  buf_clear = 1'b1;
                  state_n   = halt_req ? HALTED : FETCH;
               end else if (halt_req) begin
                  buf_clear = 1'b1;
                  state_n   = HALTED;
               end
            end
         end

         DROP: begin
            iren = 1'b1;
            if (redirect)
               target_n = rpc;
            if (imem.ihit) begin
               pc_n    = redirect ? rpc : target_q;
               state_n = FETCH;
            end
         end

         HALTED: begin
            if (redirect) begin
               pc_n    = rpc;
               state_n = FETCH;
            end
         end

         default: state_n = FETCH;
      endcase
   end

   assign imem.iREN         = iren & nRST;
   assign imem.imemaddr     = pc;
   assign ifid_instruction  = nRST ? instr : '0;
   assign ifid_pcn          = nRST ? pcn : '0;
   assign ifid_next_address = nRST ? next_addr : '0;
   assign ifid_flushed      = flushed & nRST;
   assign ifid_wen          = wen & nRST;
   assign ifid_flush        = flush & nRST;
endmodule
